// File: rtl/mdu_ctrl_pkg.sv
// Shared opcode/state types and opcode classification for the multiply/divide sequencer.
// Build option: define MDU_MADD_EN to classify MADD/MADDU/MSUB/MSUBU as multiply-class ops.
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_MULT  = 4'd0,
    MDU_MULTU = 4'd1,
    MDU_DIV   = 4'd2,
    MDU_DIVU  = 4'd3,
    MDU_MTHI  = 4'd4,
    MDU_MTLO  = 4'd5,
    MDU_MADD  = 4'd6,
    MDU_MADDU = 4'd7,
    MDU_MSUB  = 4'd8,
    MDU_MSUBU = 4'd9
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
`else
    return (op == MDU_MULT) || (op == MDU_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes/result signs on the way in, and
// two's-complement correction of the unsigned unit results on the way out.
module mdu_sign_fix (
  input  logic        [31:0] a,
  input  logic        [31:0] b,
  input  logic               sgn,
  output logic        [31:0] mag_a,
  output logic        [31:0] mag_b,
  output logic               neg_p,
  output logic               neg_r,
  input  logic        [63:0] prod,
  input  logic        [31:0] quo,
  input  logic        [31:0] rem,
  input  logic               fix_p,
  input  logic               fix_r,
  output logic        [63:0] prod_fix,
  output logic        [31:0] quo_fix,
  output logic        [31:0] rem_fix
);

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
  assign mag_a = (sgn && a[31]) ? (~a + 32'd1) : a;
  assign mag_b = (sgn && b[31]) ? (~b + 32'd1) : b;
  assign neg_p = sgn && (a[31] ^ b[31]);
  assign neg_r = sgn && a[31];

  assign prod_fix = fix_p ? (~prod + 64'd1) : prod;
  assign quo_fix  = fix_p ? (~quo + 32'd1) : quo;
  assign rem_fix  = fix_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: accepts one EX-stage request, drives the external unsigned units,
// sign-corrects results and owns HI/LO. Build option: define MDU_MADD_EN for accumulate ops.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_valid,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_c,
  output logic        div_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  mdu_state_t  state;
  logic [3:0]  op_p0;
  logic [31:0] mag_a_p0;
  logic [31:0] mag_b_p0;
  logic        neg_p_p0;
  logic        neg_r_p0;
  logic        dz_p0;
  logic [63:0] res_p1;

  logic        sgn;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_p;
  logic        neg_r;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        accept;
  logic        mul_fire;
  logic        div_fire;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign mul_fire  = mul_valid && mul_done;
  assign div_fire  = div_valid && div_done;
  assign sgn       = is_signed_op(req_op);

  assign mul_a = mag_a_p0;
  assign mul_b = mag_b_p0;
  assign div_a = mag_a_p0;
  assign div_b = mag_b_p0;

  mdu_sign_fix u_sign_fix (
    .a        (req_a),
    .b        (req_b),
    .sgn      (sgn),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .neg_p    (neg_p),
    .neg_r    (neg_r),
    .prod     (res_p1),
    .quo      (res_p1[31:0]),
    .rem      (res_p1[63:32]),
    .fix_p    (neg_p_p0),
    .fix_r    (neg_r_p0),
    .prod_fix (prod_fix),
    .quo_fix  (quo_fix),
    .rem_fix  (rem_fix)
  );

  // Unit valids are registered off the state, so operands settle one cycle before a unit starts.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      op_p0     <= 4'd0;
      mag_a_p0  <= 32'd0;
      mag_b_p0  <= 32'd0;
      neg_p_p0  <= 1'b0;
      neg_r_p0  <= 1'b0;
      dz_p0     <= 1'b0;
      res_p1    <= 64'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      mul_valid <= 1'b0;
      div_valid <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      mul_valid <= 1'b0;
      div_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_p0    <= req_op;
            mag_a_p0 <= mag_a;
            mag_b_p0 <= mag_b;
            neg_p_p0 <= neg_p;
            neg_r_p0 <= neg_r;
            dz_p0    <= (req_b == 32'd0);
            if (req_op == MDU_MTHI) begin
              hi <= req_a;
            end else if (req_op == MDU_MTLO) begin
              lo <= req_a;
            end else if (is_mul_op(req_op)) begin
              state <= MUL;
            end else if (is_div_op(req_op)) begin
              state <= DIV;
            end
          end
        end
        MUL: begin
          if (mul_fire) begin
            res_p1    <= mul_c;
            mul_valid <= 1'b0;
            state     <= FIX;
          end else begin
            mul_valid <= 1'b1;
          end
        end
        DIV: begin
          // A zero divisor never starts the divider and leaves HI/LO untouched.
          if (dz_p0) begin
            state <= IDLE;
          end else if (div_fire) begin
            res_p1    <= {div_r, div_q};
            div_valid <= 1'b0;
            state     <= FIX;
          end else begin
            div_valid <= 1'b1;
          end
        end
        FIX: begin
          state <= IDLE;
          case (op_p0)
            MDU_MULT, MDU_MULTU: begin
              {hi, lo} <= prod_fix;
            end
            MDU_DIV, MDU_DIVU: begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
              {hi, lo} <= {hi, lo} + prod_fix;
            end
            MDU_MSUB, MDU_MSUBU: begin
              {hi, lo} <= {hi, lo} - prod_fix;
            end
`endif
            default: ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized requests against a behavioural HI/LO model.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int DIV_LAT = 3;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        req_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mul_valid;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_c;
  logic        div_valid;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

  int total = 0;
  int bad = 0;
  int mul_cnt = 0;
  int div_cnt = 0;
  logic [63:0] hl;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  // External units: multiplier answers in its 2nd valid cycle, divider in its DIV_LAT-th.
  always @(posedge clk) begin
    mul_cnt <= mul_valid ? mul_cnt + 1 : 0;
    div_cnt <= div_valid ? div_cnt + 1 : 0;
  end
  assign mul_done = mul_valid && (mul_cnt == 1);
  assign mul_c    = {32'd0, mul_a} * {32'd0, mul_b};
  assign div_done = div_valid && (div_cnt == DIV_LAT - 1);
  assign div_q    = (div_b == 32'd0) ? 32'hFFFF_FFFF : div_a / div_b;
  assign div_r    = (div_b == 32'd0) ? div_a : div_a % div_b;

  mdu_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hi        (hi),
    .lo        (lo),
    .mul_valid (mul_valid),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_c     (mul_c),
    .div_valid (div_valid),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_done  (div_done),
    .div_q     (div_q),
    .div_r     (div_r)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Architectural result of one request: new {hi,lo} and number of cycles req_ready stays low.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] hl_in, output logic [63:0] hl_out,
                                output int busy);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hl_out = hl_in;
    busy = 0;
    case (op)
      MDU_MULT:  begin hl_out = 64'(sa * sb); busy = 4; end
      MDU_MULTU: begin hl_out = {32'd0, a} * {32'd0, b}; busy = 4; end
      MDU_DIV, MDU_DIVU: begin
        if (b == 32'd0) begin
          busy = 1;
        end else begin
          busy = 2 + DIV_LAT;
          if (op == MDU_DIV) hl_out = {32'(sa % sb), 32'(sa / sb)};
          else hl_out = {a % b, a / b};
        end
      end
      MDU_MTHI: hl_out[63:32] = a;
      MDU_MTLO: hl_out[31:0] = a;
      MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: begin
        if (MADD_EN) begin
          p = (op == MDU_MADD || op == MDU_MSUB) ? 64'(sa * sb) : {32'd0, a} * {32'd0, b};
          hl_out = (op == MDU_MADD || op == MDU_MADDU) ? hl_in + p : hl_in - p;
          busy = 4;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l, input int busy);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.hi = h; v.lo = l; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy, output bit to);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    busy = 0;
    to = 1'b0;
    @(negedge clk);
    while (!req_ready) begin
      busy++;
      if (busy > 200) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int eb);
    int busy;
    bit to;
    do_op(op, a, b, busy, to);
    check({name, " timeout"}, 64'(to), 64'd0);
    check({name, " busy"}, 64'(busy), 64'(eb));
    check({name, " hi"}, 64'(hi), 64'(eh));
    check({name, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [63:0] nhl;
    int eb;

    repeat (3) @(negedge clk);
    check("rst ready", 64'(req_ready), 64'd1);
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst mul_valid", 64'(mul_valid), 64'd0);
    check("rst div_valid", 64'(div_valid), 64'd0);
    check("rst mul_a", 64'(mul_a), 64'd0);
    resetn = 1'b1;

    add_vec(MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 4);
    add_vec(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4);
    add_vec(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 2 + DIV_LAT);
    add_vec(MDU_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
    add_vec(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 2 + DIV_LAT);
    add_vec(MDU_MTHI,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h8000_0000, 0);
    add_vec(MDU_MTLO,  32'h0000_ABCD, 32'd5,         32'h0000_1234, 32'h0000_ABCD, 0);
    add_vec(4'hF,      32'hDEAD_BEEF, 32'd3,         32'h0000_1234, 32'h0000_ABCD, 0);
    add_vec(MDU_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 2 + DIV_LAT);
    add_vec(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 4);
    add_vec(MDU_MTHI,  32'd0,         32'd0,         32'h0000_0000, 32'h0000_0000, 0);
    add_vec(MDU_MTLO,  32'd1,         32'd0,         32'h0000_0000, 32'h0000_0001, 0);
    if (MADD_EN) begin
      add_vec(MDU_MADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'h0000_0000, 4);
      add_vec(MDU_MSUBU, 32'd1,         32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4);
    end else begin
      add_vec(MDU_MADD,  32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 32'h0000_0001, 0);
      add_vec(MDU_MSUBU, 32'd1,         32'd2, 32'h0000_0000, 32'h0000_0001, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].busy);
    end
    hl = {vecs[vecs.size() - 1].hi, vecs[vecs.size() - 1].lo};

    // Flush during the second MUL cycle: abort, no HI/LO write.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MULT; req_a = 32'hFFFF_FFFB; req_b = 32'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fmul mul_valid", 64'(mul_valid), 64'd1);
    check("fmul mul_a", 64'(mul_a), 64'd5);
    check("fmul mul_b", 64'(mul_b), 64'd6);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("fmul ready", 64'(req_ready), 64'd1);
    check("fmul mul_valid off", 64'(mul_valid), 64'd0);
    repeat (5) @(negedge clk);
    check("fmul hilo", {hi, lo}, hl);

    // Flush in FIX beats the HI/LO write.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MULTU; req_a = 32'd2; req_b = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("ffix busy", 64'(req_ready), 64'd0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("ffix ready", 64'(req_ready), 64'd1);
    check("ffix hilo", {hi, lo}, hl);

    // Flush alongside a request in IDLE: nothing is accepted.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_MTHI; req_a = 32'hDEAD_0001; flush = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("fidle ready", 64'(req_ready), 64'd1);
    check("fidle hilo", {hi, lo}, hl);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    req_valid = 1'b1; req_op = MDU_DIVU; req_a = 32'd100; req_b = 32'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst div_valid before", 64'(div_valid), 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst ready", 64'(req_ready), 64'd1);
    check("arst hilo", {hi, lo}, 64'd0);
    check("arst div_valid", 64'(div_valid), 64'd0);
    check("arst div_a", 64'(div_a), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    hl = 64'd0;

    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      logic [31:0] a;
      logic [31:0] b;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      a = rand_operand();
      b = rand_operand();
      model(op, a, b, hl, nhl, eb);
      run_op($sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b), op, a, b,
             nhl[63:32], nhl[31:0], eb);
      hl = nhl;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
